// File: rtl/lab3_converter_structure_if.sv
// Serial code stream between a bit-serial producer and the Excess-3 to BCD converter.
// CONV_ERR_EN adds the combinational Err flag to the bundle.
interface lab3_converter_structure_if;
  logic X;
  logic Z;
`ifdef CONV_ERR_EN
  logic Err;

  modport master (output X, input Z, input Err);
  modport slave  (input X, output Z, output Err);
`else
  modport master (output X, input Z);
  modport slave  (input X, output Z);
`endif
endinterface

// File: rtl/lab3_converter_structure.sv
// Bit-serial Excess-3 to BCD converter: structural Mealy machine, three D flops plus gates.
// CONV_ERR_EN adds Err, raised on the final borrow out of bit3 (input below 3).
module lab3_converter_structure (
  input  logic                        Clk,
  input  logic                        Rst,
  lab3_converter_structure_if.slave   conv
);

  localparam int unsigned STATE_W = 3;

  // Label encodes bit position and borrow; 3'b111 is the unused code.
  localparam logic [2:0] S0 = 3'b000;
  localparam logic [2:0] S1 = 3'b001;
  localparam logic [2:0] S2 = 3'b010;
  localparam logic [2:0] S3 = 3'b011;
  localparam logic [2:0] S4 = 3'b100;
  localparam logic [2:0] S5 = 3'b101;
  localparam logic [2:0] S6 = 3'b110;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic               q2, q1, q0, x, nq2, nq1, nq0, nx;
  logic               z_c;
  logic               err_c;

  // Next-state and output logic as sum-of-products over AND/OR/NOT only.
  always_comb begin
    state_d = S0;
    z_c     = 1'b0;
    err_c   = 1'b0;
    q2      = state_q[2];
    q1      = state_q[1];
    q0      = state_q[0];
    x       = conv.X;
    nq2     = ~q2;
    nq1     = ~q1;
    nq0     = ~q0;
    nx      = ~x;

    // d2: S1 on X=0, S2, S3, and S4 either way
    state_d[2] = (nq2 & nq1 & q0 & nx) | (nq2 & q1) | (q2 & nq1 & nq0);
    // d1: S0/X=0 -> S2, S1/X=1 -> S3, S4/X=0 -> S6
    state_d[1] = (nq2 & nq1 & nq0 & nx) | (nq2 & nq1 & q0 & x) | (q2 & nq1 & nq0 & nx);
    // d0: S0/X=1 -> S1, S1/X=1 -> S3, S3 -> S5, S4/X=1 -> S5
    state_d[0] = (nq2 & nq1 & x) | (nq2 & q1 & q0) | (q2 & nq1 & nq0 & x);

    // Z passes X in S2/S3/S5, inverts it in S0/S1/S4/S6, and is 0 in the unused code.
    z_c   = (x & ((nq2 & q1) | (q2 & nq1 & q0))) | (nx & ((nq2 & nq1) | (q2 & nq0)));
    err_c = q2 & q1 & nq0 & nx;
  end

  // Three D flops with asynchronous clear to S0.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= S0;
    else     state_q <= state_d;
  end

  assign conv.Z = z_c;

`ifdef CONV_ERR_EN
  assign conv.Err = err_c;
`else
  logic unused_err;
  assign unused_err = err_c;
`endif

endmodule

// File: tb/tb_lab3_converter_structure.sv
// Directed and randomized check of the serial Excess-3 to BCD converter.
// Define CONV_ERR_EN on the command line to also check the Err flag.
module tb_lab3_converter_structure;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  lab3_converter_structure_if conv_if ();

  lab3_converter_structure dut (
    .Clk  (clk),
    .Rst  (rst),
    .conv (conv_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  `define CHECK(TAG, OBS, EXP) \
    begin \
      checks++; \
      assert ((OBS) === (EXP)) else begin \
        errors++; \
        $error("FAIL %s observed %0h expected %0h", TAG, OBS, EXP); \
      end \
    end

  // Sends one digit LSB first; starts and ends just after a rising edge.
  task automatic run_digit(input logic [3:0] e3, output logic [3:0] bcd, output logic [3:0] errs);
    for (int i = 0; i < 4; i++) begin
      conv_if.X = e3[i];
      @(negedge clk);
      bcd[i] = conv_if.Z;
`ifdef CONV_ERR_EN
      errs[i] = conv_if.Err;
`else
      errs[i] = 1'b0;
`endif
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [3:0] bcd;
    logic [3:0] errs;
    logic [3:0] e3;
    logic [3:0] exp_bcd;
    int         rand_bad;
    int         err_bad;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    conv_if.X = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    `CHECK("reset_state", dut.state_q, 3'b000)
    `CHECK("reset_z_x0", conv_if.Z, 1'b1)
    conv_if.X = 1'b1;
    #1;
    `CHECK("reset_z_x1", conv_if.Z, 1'b0)
`ifdef CONV_ERR_EN
    conv_if.X = 1'b0;
    #1;
    `CHECK("reset_err", conv_if.Err, 1'b0)
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_digit(4'b0011, bcd, errs);
    `CHECK("e3_0011", bcd, 4'b0000)
    `CHECK("s0_after_0011", dut.state_q, 3'b000)

    run_digit(4'b1100, bcd, errs);
    `CHECK("e3_1100", bcd, 4'b1001)

    run_digit(4'b0111, bcd, errs);
    `CHECK("b2b_0111", bcd, 4'b0100)
    `CHECK("b2b_s0_a", dut.state_q, 3'b000)
    run_digit(4'b1000, bcd, errs);
    `CHECK("b2b_1000", bcd, 4'b0101)
    `CHECK("b2b_s0_b", dut.state_q, 3'b000)
    run_digit(4'b0101, bcd, errs);
    `CHECK("b2b_0101", bcd, 4'b0010)
    `CHECK("b2b_s0_c", dut.state_q, 3'b000)
    `CHECK("b2b_err", errs, 4'b0000)

    // Invalid codes wrap mod 16 and leave the digit framing intact.
    run_digit(4'b0001, bcd, errs);
    `CHECK("wrap_0001", bcd, 4'b1110)
`ifdef CONV_ERR_EN
    `CHECK("err_0001", errs, 4'b1000)
`endif
    run_digit(4'b0000, bcd, errs);
    `CHECK("wrap_0000", bcd, 4'b1101)
`ifdef CONV_ERR_EN
    `CHECK("err_0000", errs, 4'b1000)
`endif
    run_digit(4'b1111, bcd, errs);
    `CHECK("wrap_1111", bcd, 4'b1100)
    `CHECK("err_1111", errs, 4'b0000)
    run_digit(4'b0100, bcd, errs);
    `CHECK("after_wrap_0100", bcd, 4'b0001)

    // Abandon 1010 after two bits with an asynchronous reset.
    conv_if.X = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    conv_if.X = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    `CHECK("mid_state_s4", dut.state_q, 3'b100)
    conv_if.X = 1'b0;
    rst = 1'b1;
    #2;
    `CHECK("async_rst_state", dut.state_q, 3'b000)
    `CHECK("async_rst_z", conv_if.Z, 1'b1)
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_digit(4'b0110, bcd, errs);
    `CHECK("post_rst_0110", bcd, 4'b0011)

    rand_bad = 0;
    err_bad  = 0;
    for (int n = 0; n < 10000; n++) begin
      e3      = 4'($urandom_range(12, 3));
      exp_bcd = 4'(e3 - 4'd3);
      run_digit(e3, bcd, errs);
      if (bcd !== exp_bcd) begin
        if (rand_bad < 5)
          $display("random digit e3=%b observed %b expected %b", e3, bcd, exp_bcd);
        rand_bad++;
      end
      if (errs !== 4'b0000) err_bad++;
    end
    `CHECK("random_bad_digits", rand_bad, 0)
    `CHECK("random_err_flags", err_bad, 0)
    `CHECK("final_state", dut.state_q, 3'b000)

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lab3_converter_structure.md
# lab3_converter_structure

Bit-serial Excess-3 to BCD code converter built as a structural Mealy state machine (gates plus D flip-flops). One Excess-3 digit arrives on `X` as four consecutive bits, LSB first, one bit per clock. The matching BCD bit (input minus 3) appears combinationally on `Z` in the same cycle. It serves as a stream-conversion leaf block; digits are back-to-back with no framing signal.

## Interface
- No parameters.
- `Clk`  input  1  system clock; state advances on rising edge.
- `Rst`  input  1  reset; asynchronous, active-high; forces state to S0.
- `X`    input  1  serial Excess-3 bit, LSB first, 4 bits per digit.
- `Z`    output 1  serial BCD bit, combinational (Mealy) from state and `X`.
- `Err`  output 1  only present with `CONV_ERR_EN`; see Configuration.

## Operation
- Serial subtraction of constant 0011: z = x ^ s ^ b, b_out = (~x & (s | b)) | (s & b), with s = 1 for bits 0–1 and s = 0 for bits 2–3.
- States are 3 flip-flops, 7 used states. The label shows bit position and borrow.
  - S0: bit0. Z = ~X. Next S2 if X=0, else S1.
  - S1: bit1, no borrow. Z = ~X. Next S4 if X=0, else S3.
  - S2: bit1, borrow. Z = X. Next S4.
  - S3: bit2, no borrow. Z = X. Next S5.
  - S4: bit2, borrow. Z = ~X. Next S6 if X=0, else S5.
  - S5: bit3, no borrow. Z = X. Next S0.
  - S6: bit3, borrow. Z = ~X. Next S0.
- Unused encoding (8th state) goes to S0 on the next clock, with Z = 0.
- After the 4th bit the machine always returns to S0. Any borrow out of bit3 is discarded, so invalid codes (0000–0010, 1101–1111) wrap mod 16 and never desynchronise later digits.
- Structural implementation:
  - Three D flip-flops with async clear.
  - Next-state and output logic from AND/OR/NOT/XOR primitives only.
  - No behavioral case statements in the top-level module.

## Timing
- Latency is 0: Z is valid combinationally once X is stable. Both must be valid before the next rising `Clk`, and the bench samples Z at the falling edge.
- X must be stable from setup before the rising edge until hold after it.
- `Rst` high: state = S0 immediately, without waiting for a clock.
  - Z follows S0 logic (Z = ~X) while reset is held.
- Reset released: the first rising edge with `Rst` low consumes bit0 of a new digit.
- Reset mid-digit: the partial digit is abandoned, and the next bit is treated as bit0.
- No enable: every rising edge consumes one bit.

## Configuration
- `CONV_ERR_EN` defined:
  - Adds output `Err`, which is combinational.
  - Err = 1 only in S6 with X = 0, i.e. during bit3 of an input below 3 (final borrow).
  - Err is 0 in all other states and during reset.
- `CONV_ERR_EN` undefined:
  - No `Err` port.
  - Logic is identical otherwise.

## Test plan
- Reset, then serial 0011 (X = 1,1,0,0 LSB first) -> Z = 0,0,0,0 (BCD 0000), ending in S0.
- Serial 1100 (X = 0,0,1,1) -> Z = 1,0,0,1 (BCD 1001).
- Back-to-back 0111, 1000, 0101 with no gaps -> BCD 0100, 0101, 0010. State is S0 at each digit boundary.
- All ten valid codes 0011..1100 in random order for 10000 digits -> BCD = Excess-3 − 3 for every digit.
- Assert `Rst` asynchronously after 2 bits of 1010, then send 0110 -> state S0 without a clock edge. Next digit gives BCD 0011.
- With `CONV_ERR_EN`, input 0001 (X = 1,0,0,0) -> Z = 0,1,1,1 (wrap 1110), Err = 1 only in the 4th bit cycle. Valid digits give Err = 0 throughout.
